conf_port_arbiter: RTL
======================

Name: conf_port_arbiter

Overview:
- Shares the single VIC-20 configuration/memory write port (address 16b, data 8b, write strobe) between three requesters:
  - the ioctl download stream (PRG/cart bytes),
  - the post-load BASIC pointer patch sequencer,
  - an internal memory fill engine used to clear or preset RAM before a load.
- Enforces a minimum spacing between writes so a slower clock-enabled consumer never misses a strobe.
- Sits in clk_sys between the loader logic and the VIC20 core's conf_* inputs.

Parameters:
- GAP, 3: minimum idle cycles between two grants; a grant at cycle N allows the next grant no earlier than N+GAP+1. GAP=0 allows back-to-back writes.
- STARVE_MAX, 8: consecutive lost arbitration opportunities after which a pending lower-priority requester is promoted to top priority for one grant.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- hold  in  1  1 = issue no new grants
- s0_valid  in  1  download stream request
- s0_addr  in  16  download write address
- s0_data  in  8  download write data
- s0_ready  out  1  download grant
- s1_valid  in  1  patch sequencer request
- s1_addr  in  16  patch write address
- s1_data  in  8  patch write data
- s1_ready  out  1  patch grant
- fill_start  in  1  single-cycle pulse: start fill
- fill_base  in  16  fill start address
- fill_len  in  17  number of bytes to fill (0..65536)
- fill_value  in  8  fill byte
- fill_busy  out  1  fill engine active
- conf_addr  out  16  registered write address
- conf_data  out  8  registered write data
- conf_wr  out  1  single-cycle write strobe
- grant_id  out  2  source of current conf_wr: 0=s0, 1=s1, 2=fill, 3=none

Behaviour:
- Reset values (reset_n low, asynchronous): conf_addr=0, conf_data=0, conf_wr=0, grant_id=3, s0_ready=0, s1_ready=0, fill_busy=0, gap counter=0, starvation counters=0, fill engine idle.
- Arbiter states:
  - IDLE: grants allowed.
  - GAP: counting down GAP cycles; no grants.
  - From IDLE, a grant moves to GAP if GAP>0, otherwise stays in IDLE.
  - GAP returns to IDLE when its count reaches 0.
- A grant is possible only in IDLE, with hold=0 and at least one requester pending.
- sX_ready is combinational: it is 1 only in the cycle that source is chosen. A transfer occurs on valid&ready.
  - Requesters must hold addr/data stable while valid=1.
  - Requesters must not drop valid before ready.
- Priority: s0 > s1 > fill.
  - Each of s1 and fill has its own saturating starvation counter.
  - The counter increments when that source is pending and another source is granted.
  - It clears when that source is granted or when it is not pending.
  - When a counter reaches STARVE_MAX, that source beats s0.
  - If both counters have reached STARVE_MAX, s1 wins.
- Latency:
  - Grant in cycle N gives conf_wr=1 in cycle N+1, with conf_addr/conf_data/grant_id registered from the winner.
  - In every other cycle conf_wr=0 and grant_id=3.
  - conf_addr/conf_data hold their last value.
- hold:
  - Blocks new grants only.
  - A strobe already registered still issues.
  - The GAP count continues to run while hold=1.
- Fill engine (sub-module):
  - On fill_start with fill idle and fill_len≠0: latch base, len and value, and set fill_busy=1 in the next cycle.
  - fill_start with fill_len=0: ignored, fill_busy stays 0.
  - fill_start while busy: ignored.
  - The engine requests with addr=current and data=value. On each grant, the address increments modulo 2^16 (0xFFFF wraps to 0x0000) and the remaining count decrements.
  - fill_busy drops in the cycle after the final grant.
- Simultaneous fill_start and final grant of a previous fill: the start is ignored, because the engine is still busy that cycle.
- Reset mid-transfer: all state is abandoned and no partial strobe is emitted after reset_n deasserts.

Decomposition:
- Package vic20_conf_pkg:
  - conf_addr_t (16b), conf_data_t (8b);
  - requester enum SRC_DL=0, SRC_PATCH=1, SRC_FILL=2, SRC_NONE=3;
  - arbiter state enum {ARB_IDLE, ARB_GAP}.
- One sub-module, conf_fill_engine: address/count registers and a valid/ready request interface to the arbiter.

Test Plan:
- GAP=3; s0_valid held with addr 0x1001..0x1004 stepping per transfer → conf_wr pulses exactly 4 cycles apart; addr/data match in order; grant_id=0.
- s0 and s1 both valid continuously, STARVE_MAX=8 → 8 s0 writes, then 1 s1 write, repeating; the s1 starvation counter clears after each s1 grant.
- fill_start, base=0xFFFE, len=4, value=0x00 → writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001; fill_busy high from start+1 until the cycle after the 4th grant.
- hold=1 asserted in the cycle after a grant → that strobe still appears; no further grants until hold=0. fill_start with len=0 → fill_busy stays 0 and no writes.
- reset_n pulsed low mid-fill (after 2 of 10 writes) → all outputs at reset values immediately; no conf_wr after release until a new request.
- GAP=0, s1 valid alone for 5 transfers → conf_wr high for 5 consecutive cycles; grant_id=1.

Source files
------------

// File: rtl/vic20_conf_pkg.sv
// Shared types for the VIC-20 configuration write port: address/data widths, requester ids, arbiter states.
// Pure type/constant package: no logic, no latency, no flow control.
package vic20_conf_pkg;
   typedef logic [15:0] conf_addr_t;
   typedef logic [7:0]  conf_data_t;

   typedef enum logic [1:0] {
      SRC_DL    = 2'd0,
      SRC_PATCH = 2'd1,
      SRC_FILL  = 2'd2,
      SRC_NONE  = 2'd3
   } conf_src_e;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_GAP  = 1'b1
   } arb_state_e;
endpackage

// File: rtl/conf_fill_engine.sv
// Memory fill engine: after fill_start, walks base..base+len-1 (wrapping at 64K) one request per grant.
// req_valid is busy; the request holds until req_ready; fill_busy drops the cycle after the final grant.
module conf_fill_engine
   import vic20_conf_pkg::*;
(
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        fill_start,
   input  logic [15:0] fill_base,
   input  logic [16:0] fill_len,
   input  logic [7:0]  fill_value,
   output logic        fill_busy,
   output logic        req_valid,
   input  logic        req_ready,
   output logic [15:0] req_addr,
   output logic [7:0]  req_data
);
   conf_addr_t  cur_addr;
   conf_data_t  value;
   logic [16:0] remain;
   logic        busy;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         busy     <= 1'b0;
         cur_addr <= '0;
         remain   <= '0;
         value    <= '0;
      end else if (busy) begin
         // A start arriving while busy (even on the last grant) is dropped.
         if (req_ready) begin
            cur_addr <= cur_addr + 16'd1;
            remain   <= remain - 17'd1;
            if (remain == 17'd1)
               busy <= 1'b0;
         end
      end else if (fill_start && (fill_len != '0)) begin
         busy     <= 1'b1;
         cur_addr <= fill_base;
         remain   <= fill_len;
         value    <= fill_value;
      end
   end

   assign fill_busy = busy;
   assign req_valid = busy;
   assign req_addr  = cur_addr;
   assign req_data  = value;
endmodule

// File: rtl/conf_port_arbiter.sv
// Shares the conf write port between download (s0), patch (s1) and fill; a grant in cycle N strobes conf_wr in N+1.
// Ready is combinational and single-cycle; GAP idle cycles follow each grant and hold blocks new grants only.
module conf_port_arbiter
   import vic20_conf_pkg::*;
#(
   parameter int GAP        = 3,
   parameter int STARVE_MAX = 8
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        hold,
   input  logic        s0_valid,
   input  logic [15:0] s0_addr,
   input  logic [7:0]  s0_data,
   output logic        s0_ready,
   input  logic        s1_valid,
   input  logic [15:0] s1_addr,
   input  logic [7:0]  s1_data,
   output logic        s1_ready,
   input  logic        fill_start,
   input  logic [15:0] fill_base,
   input  logic [16:0] fill_len,
   input  logic [7:0]  fill_value,
   output logic        fill_busy,
   output logic [15:0] conf_addr,
   output logic [7:0]  conf_data,
   output logic        conf_wr,
   output logic [1:0]  grant_id
);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [GW-1:0] GAP_LOAD   = GW'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   logic       fill_req_valid, fill_req_ready;
   conf_addr_t fill_req_addr;
   conf_data_t fill_req_data;

   arb_state_e    state_q, state_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [SW-1:0] starve_patch, starve_fill;
   logic          patch_starved, fill_starved, grant_ok;
   conf_src_e     win;

   conf_fill_engine u_fill (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .fill_start (fill_start),
      .fill_base  (fill_base),
      .fill_len   (fill_len),
      .fill_value (fill_value),
      .fill_busy  (fill_busy),
      .req_valid  (fill_req_valid),
      .req_ready  (fill_req_ready),
      .req_addr   (fill_req_addr),
      .req_data   (fill_req_data)
   );

   assign patch_starved = (starve_patch >= STARVE_LIM);
   assign fill_starved  = (starve_fill >= STARVE_LIM);
   assign grant_ok      = (state_q == ARB_IDLE) && !hold && (s0_valid || s1_valid || fill_req_valid);

   // Starved sources jump ahead of s0; if both are starved, patch goes first.
   always_comb begin
      win = SRC_NONE;
      if (grant_ok) begin
         if (patch_starved && s1_valid)           win = SRC_PATCH;
         else if (fill_starved && fill_req_valid) win = SRC_FILL;
         else if (s0_valid)                       win = SRC_DL;
         else if (s1_valid)                       win = SRC_PATCH;
         else                                     win = SRC_FILL;
      end
   end

   assign s0_ready       = (win == SRC_DL);
   assign s1_ready       = (win == SRC_PATCH);
   assign fill_req_ready = (win == SRC_FILL);

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      case (state_q)
         ARB_IDLE: begin
            if ((win != SRC_NONE) && (GAP > 0)) begin
               state_d = ARB_GAP;
               gap_d   = GAP_LOAD;
            end
         end
         ARB_GAP: begin
            if (gap_q == '0) state_d = ARB_IDLE;
            else             gap_d   = gap_q - GW'(1);
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ARB_IDLE;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         starve_patch <= '0;
         starve_fill  <= '0;
      end else begin
         if (!s1_valid || (win == SRC_PATCH))           starve_patch <= '0;
         else if ((win != SRC_NONE) && !patch_starved)  starve_patch <= starve_patch + SW'(1);
         if (!fill_req_valid || (win == SRC_FILL))      starve_fill  <= '0;
         else if ((win != SRC_NONE) && !fill_starved)   starve_fill  <= starve_fill + SW'(1);
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         conf_wr   <= 1'b0;
         grant_id  <= SRC_NONE;
         conf_addr <= '0;
         conf_data <= '0;
      end else begin
         conf_wr  <= (win != SRC_NONE);
         grant_id <= win;
         case (win)
            SRC_DL:    begin conf_addr <= s0_addr;       conf_data <= s0_data;       end
            SRC_PATCH: begin conf_addr <= s1_addr;       conf_data <= s1_data;       end
            SRC_FILL:  begin conf_addr <= fill_req_addr; conf_data <= fill_req_data; end
            default:   ;
         endcase
      end
   end
endmodule
